// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the op encodings, the FSM state encodings and the default operand width.
package mdu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: magnitudes of signed operands on issue,
// and sign correction of the unsigned product/quotient/remainder at FIX.
import mdu_pkg::*;

module mdu_sign_fix #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               op_signed,
    output logic [WIDTH-1:0]   abs_a,
    output logic [WIDTH-1:0]   abs_b,
    output logic               a_neg,
    output logic               b_neg,
    input  logic [2*WIDTH-1:0] acc,
    input  logic               res_div,
    input  logic               res_a_neg,
    input  logic               res_b_neg,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        a_neg  = op_signed & a[WIDTH-1];
        b_neg  = op_signed & b[WIDTH-1];
        abs_a  = a_neg ? -a : a;
        abs_b  = b_neg ? -b : b;

        prod   = (res_a_neg ^ res_b_neg) ? -acc : acc;
        quo    = (res_a_neg ^ res_b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = res_a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

        res_hi = res_div ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = res_div ? quo : prod[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: WIDTH-step shift-add multiply and
// restoring divide, a sign-fix cycle, then a one-cycle done pulse.
import mdu_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e             state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   reg_b;
    logic [WIDTH-1:0]   orig_a;
    logic               is_div;
    logic               sa_neg;
    logic               sb_neg;

    logic               op_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_next;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a         (src_a),
        .b         (src_b),
        .op_signed (op_signed),
        .abs_a     (abs_a),
        .abs_b     (abs_b),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .acc       (acc),
        .res_div   (is_div),
        .res_a_neg (sa_neg),
        .res_b_neg (sb_neg),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    // Restoring step: acc holds {remainder, dividend bits still being shifted in / quotient bits}.
    always_comb begin
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff      = rem_shift - {1'b0, reg_b};
        if (!diff[WIDTH])
            div_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // NOTE: state is updated with non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            reg_b  <= '0;
            orig_a <= '0;
            is_div <= 1'b0;
            sa_neg <= 1'b0;
            sb_neg <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div <= (op == OP_DIV) || (op == OP_DIVU);
                                sa_neg <= a_neg;
                                sb_neg <= b_neg;
                                orig_a <= src_a;
                                reg_b  <= abs_b;
                                count  <= '0;
                                busy   <= 1'b1;
                                if ((op == OP_DIV) || (op == OP_DIVU)) begin
                                    acc   <= {{WIDTH{1'b0}}, abs_a};
                                    mcand <= '0;
                                    state <= DIV;
                                end else begin
                                    acc   <= '0;
                                    mcand <= {{WIDTH{1'b0}}, abs_a};
                                    state <= MUL;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (reg_b[0])
                        acc <= acc + mcand;
                    mcand <= mcand << 1;
                    reg_b <= reg_b >> 1;
                    count <= count + 1'b1;
                    if (count == LAST)
                        state <= FIX;
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count + 1'b1;
                    if (count == LAST)
                        state <= FIX;
                end
                FIX: begin
                    if (is_div && (reg_b == '0)) begin
                        hi <= orig_a;
                        lo <= '1;
                    end else begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, randomized ops
// against an arithmetic reference model, issue-while-busy and mid-operation reset.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            3'b000: p = 64'(sa * sb);
            3'b001: p = {32'b0, a} * {32'b0, b};
            3'b010: begin
                if (b == 0)
                    p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    p = {32'h0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'b011: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: p = '0;
        endcase
        return p;
    endfunction

    // Issue one arithmetic op and follow it to done. repulse_at >= 0 drives a
    // second start while busy; poke_done drives an MTHI start during the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int repulse_at, input bit poke_done);
        logic [63:0] exp;
        int          k;
        bit          ok;
        exp = ref_result(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; src_a = $urandom; src_b = $urandom;
        k  = 0;
        ok = 1'b1;
        while (!done && k < 100) begin
            if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) ok = 1'b0;
            start = (k == repulse_at);
            if (start) begin
                op = 3'b000; src_a = 32'd7; src_b = 32'd3;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        // Cycle index counted with the cycle right after the start edge as 1.
        check({tag, "_done_cycle"}, 64'(k + 1), 64'(W + 2));
        check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
        check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        check({tag, "_stable_while_busy"}, 64'(ok), 64'(1));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        if (poke_done) begin
            start = 1'b1; op = 3'b100; src_a = 32'hDEAD_BEEF;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_start_in_done_ignored"}, 64'(hi), 64'(m_hi));
        end else begin
            @(negedge clk);
        end
        check({tag, "_done_pulse_ends"}, 64'(done), 64'(0));
    endtask

    // One-cycle ops (MTHI/MTLO) and reserved encodings.
    task automatic mt_op(input logic [2:0] o, input logic [31:0] a, input string tag);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        if (o == 3'b100) m_hi = a;
        if (o == 3'b101) m_lo = a;
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          seen_done;

        rst = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        rst = 1'b1;

        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", -1, 1'b0);
        run_op(3'b000, -32'sd3, 32'd7, "mult_neg", -1, 1'b1);
        run_op(3'b010, -32'sd7, 32'd2, "div_neg", -1, 1'b0);
        run_op(3'b010, 32'd7, -32'sd2, "div_negdivisor", -1, 1'b0);
        run_op(3'b011, 32'd100, 32'd0, "divu_by_zero", -1, 1'b0);
        run_op(3'b010, -32'sd5, 32'd0, "div_by_zero", -1, 1'b0);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", -1, 1'b0);
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, "mult_minmin", -1, 1'b0);

        mt_op(3'b101, 32'hCAFE_0001, "mtlo");
        mt_op(3'b110, 32'h5555_5555, "reserved_110");
        mt_op(3'b111, 32'hAAAA_AAAA, "reserved_111");

        mt_op(3'b100, 32'h0000_1234, "mthi");
        run_op(3'b011, 32'd9, 32'd4, "divu_repulse", 3, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            run_op(ro, ra, rb, $sformatf("rand%0d", i), -1, 1'b0);
        end

        // Mid-operation reset discards the op: no done, architectural state cleared.
        @(negedge clk);
        start = 1'b1; op = 3'b001; src_a = $urandom; src_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_done", 64'(done), 64'(0));
        check("midreset_hi", 64'(hi), 64'(0));
        check("midreset_lo", 64'(lo), 64'(0));
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("midreset_no_done", 64'(seen_done), 64'(0));
        run_op(3'b000, 32'd123456, -32'sd789, "after_reset", -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
